mem_access_ctrl: RTL and testbench

- Sequences the data-memory access for the instruction held in the EX/MEM pipeline register.
- Takes the register's control bits, address and store data, and drives a req/ack handshake to the data memory.
- Asserts a pipeline stall that freezes PC, IF/ID, ID/EX and EX/MEM until the access completes.
- Returns load data to the MEM/WB register with a valid strobe, and flags misaligned and timed-out accesses.

---
 rtl/mem_access_ctrl_if.sv | 20 ++
 rtl/mem_access_ctrl.sv | 125 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Request/acknowledge bus between the pipeline's memory-access controller and data memory.
// Handshake: mem_req stays high with mem_we/mem_addr/mem_wdata stable until a cycle with mem_ack=1 (mem_rdata valid then).
interface mem_access_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Sequences the EX/MEM data-memory access over a req/ack bus, stalling the pipeline until it completes.
// Misaligned accesses are dropped with a one-cycle flag; unanswered requests abort after TIMEOUT cycles.
module mem_access_ctrl #(
    parameter int MEMREAD_BIT  = 3,
    parameter int MEMWRITE_BIT = 2,
    parameter int TIMEOUT      = 16,
    parameter int CNT_W        = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [8:0]          i_ctrl_sig,
    input  logic [31:0]         i_address,
    input  logic [31:0]         i_write_data,
    input  logic                i_err_clr,
    mem_access_ctrl_if.master   mem,
    output logic                o_stall,
    output logic [31:0]         o_read_data,
    output logic                o_rdata_valid,
    output logic                o_misalign_err,
    output logic                o_timeout_err,
    output logic [1:0]          o_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_req;
    logic               r_we;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [31:0]        r_read_data;
    logic               r_rdata_valid;
    logic               r_misalign_err;
    logic               r_timeout_err;
    logic [CNT_W-1:0]   r_cnt;

    logic w_mem_read;
    logic w_mem_write;
    logic w_op;
    logic w_aligned;
    logic w_unused_ctrl;

    assign w_mem_read    = i_ctrl_sig[MEMREAD_BIT];
    assign w_mem_write   = i_ctrl_sig[MEMWRITE_BIT];
    assign w_op          = w_mem_read | w_mem_write;
    assign w_aligned     = (i_address[1:0] == 2'b00);
    assign w_unused_ctrl = &{1'b0, i_ctrl_sig};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_req          <= 1'b0;
            r_we           <= 1'b0;
            r_addr         <= 32'd0;
            r_wdata        <= 32'd0;
            r_read_data    <= 32'd0;
            r_rdata_valid  <= 1'b0;
            r_misalign_err <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_cnt          <= '0;
        end else begin
            r_rdata_valid  <= 1'b0;
            r_misalign_err <= 1'b0;
            // A timeout set below overrides this clear in the same cycle.
            if (i_err_clr) r_timeout_err <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_op && w_aligned) begin
                        r_addr  <= i_address;
                        r_wdata <= i_write_data;
                        r_we    <= w_mem_write;
                        r_req   <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= ACCESS;
                    end else if (w_op) begin
                        r_misalign_err <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (mem.mem_ack) begin
                        if (!r_we) r_read_data <= mem.mem_rdata;
                        r_req         <= 1'b0;
                        r_rdata_valid <= 1'b1;
                        r_state       <= DONE;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_req         <= 1'b0;
                        r_read_data   <= 32'd0;
                        r_timeout_err <= 1'b1;
                        r_rdata_valid <= 1'b1;
                        r_state       <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    // DONE deliberately drops stall so the pipeline advances past the finished instruction.
    assign o_stall = ((r_state == IDLE) && w_op && w_aligned) || (r_state == ACCESS);

    assign mem.mem_req   = r_req;
    assign mem.mem_we    = r_we;
    assign mem.mem_addr  = r_addr;
    assign mem.mem_wdata = r_wdata;

    assign o_read_data    = r_read_data;
    assign o_rdata_valid  = r_rdata_valid;
    assign o_misalign_err = r_misalign_err;
    assign o_timeout_err  = r_timeout_err;
    assign o_state        = r_state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: load/store latency, misalignment, timeout, back-to-back and async reset.
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic [8:0]  ctrl_sig;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        err_clr;
    logic        stall;
    logic [31:0] read_data;
    logic        rdata_valid;
    logic        misalign_err;
    logic        timeout_err;
    logic [1:0]  state;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [8:0] LOAD  = 9'h008;
    localparam logic [8:0] STORE = 9'h004;
    localparam logic [8:0] BOTH  = 9'h00C;

    mem_access_ctrl_if mem_bus ();

    mem_access_ctrl #(
        .MEMREAD_BIT  (3),
        .MEMWRITE_BIT (2),
        .TIMEOUT      (16),
        .CNT_W        (5)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_ctrl_sig     (ctrl_sig),
        .i_address      (address),
        .i_write_data   (write_data),
        .i_err_clr      (err_clr),
        .mem            (mem_bus),
        .o_stall        (stall),
        .o_read_data    (read_data),
        .o_rdata_valid  (rdata_valid),
        .o_misalign_err (misalign_err),
        .o_timeout_err  (timeout_err),
        .o_state        (state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // scoreboard
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [8:0] c, input logic [31:0] a, input logic [31:0] wd);
        ctrl_sig   = c;
        address    = a;
        write_data = wd;
        #1;
    endtask

    initial begin
        int n_req;
        int n_cyc;

        rst_n             = 1'b0;
        ctrl_sig          = '0;
        address           = '0;
        write_data        = '0;
        err_clr           = 1'b0;
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = '0;
        #1;
        check("rst_req", mem_bus.mem_req, 0);
        check("rst_valid", rdata_valid, 0);
        check("rst_read_data", read_data, 0);
        check("rst_state", state, 0);
        #20 rst_n = 1'b1;

        // load, zero wait
        step();
        drive_op(LOAD, 32'h0000_0010, 32'h0);
        check("ld_stall_t0", stall, 1);
        check("ld_req_t0", mem_bus.mem_req, 0);
        step();
        check("ld_req_t1", mem_bus.mem_req, 1);
        check("ld_we_t1", mem_bus.mem_we, 0);
        check("ld_addr_t1", mem_bus.mem_addr, 32'h10);
        check("ld_stall_t1", stall, 1);
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_bus.mem_ack   = 1'b0;
        check("ld_valid_t2", rdata_valid, 1);
        check("ld_rdata_t2", read_data, 32'hDEAD_BEEF);
        check("ld_stall_t2", stall, 0);
        check("ld_req_t2", mem_bus.mem_req, 0);
        drive_op(9'h0, 32'h0, 32'h0);
        step();
        check("ld_req_t3", mem_bus.mem_req, 0);
        check("ld_valid_t3", rdata_valid, 0);

        // store, ack on third access cycle
        drive_op(STORE, 32'h24, 32'h1234_5678);
        check("st_stall_t0", stall, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("st_req", mem_bus.mem_req, 1);
            check("st_we", mem_bus.mem_we, 1);
            check("st_wdata", mem_bus.mem_wdata, 32'h1234_5678);
            check("st_stall", stall, 1);
            check("st_valid_early", rdata_valid, 0);
            if (i == 2) begin
                mem_bus.mem_ack   = 1'b1;
                mem_bus.mem_rdata = 32'hAAAA_5555;
            end
        end
        step();
        mem_bus.mem_ack = 1'b0;
        check("st_valid", rdata_valid, 1);
        check("st_rdata_kept", read_data, 32'hDEAD_BEEF);
        check("st_stall_done", stall, 0);
        drive_op(9'h0, 32'h0, 32'h0);
        step();
        check("st_valid_once", rdata_valid, 0);

        // misaligned load
        drive_op(LOAD, 32'h0000_0013, 32'h0);
        check("mis_stall", stall, 0);
        step();
        check("mis_err", misalign_err, 1);
        check("mis_req", mem_bus.mem_req, 0);
        check("mis_state", state, 0);
        drive_op(9'h0, 32'h0, 32'h0);
        step();
        check("mis_err_pulse", misalign_err, 0);

        // timeout with err_clr held through the abort: set wins
        drive_op(LOAD, 32'h40, 32'h0);
        err_clr = 1'b1;
        n_req = 0;
        n_cyc = 0;
        do begin
            step();
            n_cyc++;
            if (mem_bus.mem_req) n_req++;
        end while (!rdata_valid && n_cyc < 40);
        err_clr = 1'b0;
        check("to_req_cycles", n_req, 16);
        check("to_valid", rdata_valid, 1);
        check("to_rdata", read_data, 0);
        check("to_err_set_wins", timeout_err, 1);
        check("to_req_done", mem_bus.mem_req, 0);
        drive_op(9'h0, 32'h0, 32'h0);
        step();
        step();
        check("to_err_sticky", timeout_err, 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("to_err_cleared", timeout_err, 0);

        // back-to-back load then store
        drive_op(LOAD, 32'h50, 32'h0);
        step();
        check("b2b_ld_addr", mem_bus.mem_addr, 32'h50);
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 32'h0BAD_F00D;
        step();
        mem_bus.mem_ack = 1'b0;
        check("b2b_ld_valid", rdata_valid, 1);
        check("b2b_ld_rdata", read_data, 32'h0BAD_F00D);
        drive_op(STORE, 32'h54, 32'hCAFE_F00D);
        check("b2b_done_stall", stall, 0);
        step();
        check("b2b_no_dup_req", mem_bus.mem_req, 0);
        check("b2b_st_stall", stall, 1);
        step();
        check("b2b_st_req", mem_bus.mem_req, 1);
        check("b2b_st_we", mem_bus.mem_we, 1);
        check("b2b_st_addr", mem_bus.mem_addr, 32'h54);
        mem_bus.mem_ack = 1'b1;
        step();
        mem_bus.mem_ack = 1'b0;
        check("b2b_st_valid", rdata_valid, 1);
        check("b2b_st_rdata_kept", read_data, 32'h0BAD_F00D);
        drive_op(9'h0, 32'h0, 32'h0);
        step();

        // both read and write bits: treated as store
        drive_op(BOTH, 32'h60, 32'h5555_0000);
        step();
        check("both_we", mem_bus.mem_we, 1);
        mem_bus.mem_ack = 1'b1;
        step();
        mem_bus.mem_ack = 1'b0;
        check("both_rdata_kept", read_data, 32'h0BAD_F00D);
        drive_op(9'h0, 32'h0, 32'h0);
        step();

        // async reset in the middle of an access
        drive_op(LOAD, 32'h70, 32'h0);
        step();
        check("rr_req_before", mem_bus.mem_req, 1);
        #2;
        rst_n    = 1'b0;
        ctrl_sig = '0;
        #1;
        check("rr_req", mem_bus.mem_req, 0);
        check("rr_stall", stall, 0);
        check("rr_state", state, 0);
        check("rr_addr", mem_bus.mem_addr, 0);
        check("rr_rdata", read_data, 0);
        #10 rst_n = 1'b1;
        step();
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 32'h7777_7777;
        step();
        mem_bus.mem_ack = 1'b0;
        check("rr_late_ack_valid", rdata_valid, 0);
        step();
        check("rr_late_ack_valid2", rdata_valid, 0);
        check("rr_late_ack_rdata", read_data, 0);

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
